gbf_refill_scheduler: RTL and testbench

- Sequences refills of the four ping-pong global buffers (actv buf1/buf2, wgt buf1/buf2) in gbf_pe_array from a single shared off-chip source stream.
- Arbitrates between actv and wgt refill demand and issues one fetch request per buffer fill.
- Streams the returned beats into GBF port A and drives the gbf_*_data_avail and gbf_*_buf*_ready handshakes consumed by gbf_controller.
- Sits between the DRAM/DMA front end and gbf_pe_array.

---
 rtl/gbf_refill_scheduler.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_gbf_refill_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbf_refill_scheduler.sv
// ---------------------------------------------------------------------------
// gbf_refill_scheduler
//
// Refills the four ping-pong global buffers of gbf_pe_array (actv buf1/buf2,
// wgt buf1/buf2) from one shared off-chip source stream. The block arbitrates
// round-robin between actv and wgt refill demand and issues one fetch request
// per buffer fill. It writes the returned beats into GBF port A one cycle
// after each accepted beat and tracks EMPTY/FILLING/FULL state per buffer for
// the gbf_controller handshakes.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, finish         layer start pulse (samples cfg_*), layer abort/end
//   cfg_actv_fills        actv buffer fills for the layer
//   cfg_wgt_fills         wgt buffer fills for the layer
//   cfg_beats             rows per fill (0 selects GBF_DEPTH)
//   *_need_data           per-buffer refill demand level from gbf_controller
//   req_valid/id/tile     fetch request (id: 0 actv1, 1 actv2, 2 wgt1, 3 wgt2)
//   req_ready             request accepted by the source
//   src_valid/data/ready  returned beat stream
//   gbf_wr_addr/data      shared port-A address and write data
//   *_en?a, *_we?a        per-buffer port-A enable and write enable
//   gbf_*_data_avail      sticky: buf1 of that type has been filled
//   gbf_*_buf?_ready      buffer is FULL
//   layer_done            one-cycle pulse when every fill of the layer is done
//
// Optional build macro GBF_REFILL_PERF_EN adds the saturating counters
// perf_src_stall (XFER cycles without src_valid) and perf_req_wait
// (REQ cycles without req_ready).
// ---------------------------------------------------------------------------
module gbf_refill_scheduler #(
  parameter int GBF_DATA_BITWIDTH = 256,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32,
  parameter int TILE_CNT_BITWIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         finish,
  input  logic [TILE_CNT_BITWIDTH-1:0] cfg_actv_fills,
  input  logic [TILE_CNT_BITWIDTH-1:0] cfg_wgt_fills,
  input  logic [GBF_ADDR_BITWIDTH:0]   cfg_beats,
  input  logic                         actv_gbf1_need_data,
  input  logic                         actv_gbf2_need_data,
  input  logic                         wgt_gbf1_need_data,
  input  logic                         wgt_gbf2_need_data,
  output logic                         req_valid,
  output logic [1:0]                   req_id,
  output logic [TILE_CNT_BITWIDTH-1:0] req_tile,
  input  logic                         req_ready,
  input  logic                         src_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0] src_data,
  output logic                         src_ready,
  output logic [GBF_ADDR_BITWIDTH-1:0] gbf_wr_addr,
  output logic [GBF_DATA_BITWIDTH-1:0] gbf_wr_data,
  output logic                         actv_en1a,
  output logic                         actv_we1a,
  output logic                         actv_en2a,
  output logic                         actv_we2a,
  output logic                         wgt_en1a,
  output logic                         wgt_we1a,
  output logic                         wgt_en2a,
  output logic                         wgt_we2a,
  output logic                         gbf_actv_data_avail,
  output logic                         gbf_wgt_data_avail,
  output logic                         gbf_actv_buf1_ready,
  output logic                         gbf_actv_buf2_ready,
  output logic                         gbf_wgt_buf1_ready,
  output logic                         gbf_wgt_buf2_ready,
  output logic                         layer_done
`ifdef GBF_REFILL_PERF_EN
  ,
  output logic [31:0]                  perf_src_stall,
  output logic [31:0]                  perf_req_wait
`endif
);

  localparam int AW = GBF_ADDR_BITWIDTH;
  localparam int DW = GBF_DATA_BITWIDTH;
  localparam int TW = TILE_CNT_BITWIDTH;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_XFER, S_DONE} state_t;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL} bstate_t;

  state_t        state_q;
  bstate_t       bst_q [4];
  logic [TW-1:0] actv_fills_q, wgt_fills_q, actv_iss_q, wgt_iss_q;
  logic [AW:0]   beats_q, beat_cnt_q;
  logic          actv_ptr_q, wgt_ptr_q, rr_q;
  logic [1:0]    tgt_q;
  logic [TW-1:0] req_tile_q;
  logic          req_valid_q, src_ready_q, layer_done_q;
  logic          wr_pend_q, wr_last_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic          actv_avail_q, wgt_avail_q;
  logic [3:0]    need_prev_q;

  logic [3:0]    need_now, need_rise;
  logic          actv_elig, wgt_elig, pick_wgt, any_filling, all_issued;
  logic [1:0]    grant_id;
  logic [AW:0]   beats_eff, beats_m1;
  logic          beat_acc, last_acc, start_acc;

  always_comb begin
    need_now   = {wgt_gbf2_need_data, wgt_gbf1_need_data,
                  actv_gbf2_need_data, actv_gbf1_need_data};
    need_rise  = need_now & ~need_prev_q;
    actv_elig  = (actv_iss_q < actv_fills_q) && (bst_q[{1'b0, actv_ptr_q}] == B_EMPTY);
    wgt_elig   = (wgt_iss_q < wgt_fills_q) && (bst_q[{1'b1, wgt_ptr_q}] == B_EMPTY);
    // rr_q set means wgt holds priority on the next tie
    pick_wgt   = wgt_elig && (!actv_elig || rr_q);
    grant_id   = pick_wgt ? {1'b1, wgt_ptr_q} : {1'b0, actv_ptr_q};
    any_filling = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bst_q[i] == B_FILLING) any_filling = 1'b1;
    end
    all_issued = (actv_iss_q >= actv_fills_q) && (wgt_iss_q >= wgt_fills_q);
    beats_eff  = (beats_q == '0) ? (AW+1)'(GBF_DEPTH) : beats_q;
    beats_m1   = beats_eff - (AW+1)'(1);
    beat_acc   = src_valid && src_ready_q;
    last_acc   = beat_acc && (beat_cnt_q == beats_m1);
    start_acc  = start && (state_q == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      actv_fills_q <= '0;
      wgt_fills_q  <= '0;
      actv_iss_q   <= '0;
      wgt_iss_q    <= '0;
      beats_q      <= '0;
      beat_cnt_q   <= '0;
      actv_ptr_q   <= 1'b0;
      wgt_ptr_q    <= 1'b0;
      rr_q         <= 1'b0;
      tgt_q        <= '0;
      req_tile_q   <= '0;
      req_valid_q  <= 1'b0;
      src_ready_q  <= 1'b0;
      layer_done_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_last_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      actv_avail_q <= 1'b0;
      wgt_avail_q  <= 1'b0;
      need_prev_q  <= '0;
      for (int i = 0; i < 4; i++) bst_q[i] <= B_EMPTY;
    end else if (finish) begin
      // Abort: any half-written buffer is dropped and the pending write killed
      state_q      <= S_IDLE;
      req_valid_q  <= 1'b0;
      src_ready_q  <= 1'b0;
      layer_done_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_last_q    <= 1'b0;
      beat_cnt_q   <= '0;
      actv_avail_q <= 1'b0;
      wgt_avail_q  <= 1'b0;
      need_prev_q  <= need_now;
      for (int i = 0; i < 4; i++) bst_q[i] <= B_EMPTY;
    end else begin
      need_prev_q  <= need_now;
      wr_pend_q    <= 1'b0;
      layer_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (bst_q[i] == B_FULL && need_rise[i]) bst_q[i] <= B_EMPTY;
      end
      // Buffer turns FULL the cycle after its last write strobe
      if (wr_pend_q && wr_last_q) begin
        bst_q[tgt_q] <= B_FULL;
        if (tgt_q == 2'd0) actv_avail_q <= 1'b1;
        if (tgt_q == 2'd2) wgt_avail_q  <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (start_acc) begin
            actv_fills_q <= cfg_actv_fills;
            wgt_fills_q  <= cfg_wgt_fills;
            beats_q      <= cfg_beats;
            actv_iss_q   <= '0;
            wgt_iss_q    <= '0;
            actv_ptr_q   <= 1'b0;
            wgt_ptr_q    <= 1'b0;
            rr_q         <= 1'b0;
            actv_avail_q <= 1'b0;
            wgt_avail_q  <= 1'b0;
            state_q      <= S_ARB;
          end
        end
        S_ARB: begin
          if (actv_elig || wgt_elig) begin
            tgt_q           <= grant_id;
            bst_q[grant_id] <= B_FILLING;
            rr_q            <= !pick_wgt;
            if (pick_wgt) begin
              req_tile_q <= wgt_iss_q;
              wgt_iss_q  <= wgt_iss_q + TW'(1);
              wgt_ptr_q  <= !wgt_ptr_q;
            end else begin
              req_tile_q <= actv_iss_q;
              actv_iss_q <= actv_iss_q + TW'(1);
              actv_ptr_q <= !actv_ptr_q;
            end
            req_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end else if (all_issued && !any_filling) begin
            layer_done_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_REQ: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            src_ready_q <= 1'b1;
            beat_cnt_q  <= '0;
            state_q     <= S_XFER;
          end
        end
        S_XFER: begin
          if (beat_acc) begin
            wr_pend_q <= 1'b1;
            wr_last_q <= last_acc;
            wr_addr_q <= beat_cnt_q[AW-1:0];
            wr_data_q <= src_data;
            if (last_acc) begin
              beat_cnt_q  <= '0;
              src_ready_q <= 1'b0;
              state_q     <= S_ARB;
            end else begin
              beat_cnt_q <= beat_cnt_q + (AW+1)'(1);
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef GBF_REFILL_PERF_EN
  logic [31:0] stall_q, wait_q;

  always_ff @(posedge clk) begin
    if (reset || (start_acc && !finish)) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else begin
      if (state_q == S_XFER && !src_valid && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (state_q == S_REQ && !req_ready && wait_q != '1)   wait_q  <= wait_q + 32'd1;
    end
  end

  assign perf_src_stall = stall_q;
  assign perf_req_wait  = wait_q;
`endif

  assign req_valid   = req_valid_q;
  assign req_id      = tgt_q & {2{req_valid_q}};
  assign req_tile    = req_tile_q & {TW{req_valid_q}};
  assign src_ready   = src_ready_q;
  assign gbf_wr_addr = wr_addr_q;
  assign gbf_wr_data = wr_data_q;
  assign actv_en1a   = wr_pend_q && (tgt_q == 2'd0);
  assign actv_we1a   = actv_en1a;
  assign actv_en2a   = wr_pend_q && (tgt_q == 2'd1);
  assign actv_we2a   = actv_en2a;
  assign wgt_en1a    = wr_pend_q && (tgt_q == 2'd2);
  assign wgt_we1a    = wgt_en1a;
  assign wgt_en2a    = wr_pend_q && (tgt_q == 2'd3);
  assign wgt_we2a    = wgt_en2a;
  assign gbf_actv_data_avail = actv_avail_q;
  assign gbf_wgt_data_avail  = wgt_avail_q;
  assign gbf_actv_buf1_ready = (bst_q[0] == B_FULL);
  assign gbf_actv_buf2_ready = (bst_q[1] == B_FULL);
  assign gbf_wgt_buf1_ready  = (bst_q[2] == B_FULL);
  assign gbf_wgt_buf2_ready  = (bst_q[3] == B_FULL);
  assign layer_done  = layer_done_q;

endmodule

// File: tb/tb_gbf_refill_scheduler.sv
module tb_gbf_refill_scheduler;

  logic         clk;
  logic         reset, start, finish;
  logic [7:0]   cfg_actv_fills, cfg_wgt_fills;
  logic [5:0]   cfg_beats;
  logic         actv_gbf1_need_data, actv_gbf2_need_data;
  logic         wgt_gbf1_need_data, wgt_gbf2_need_data;
  logic         req_valid;
  logic [1:0]   req_id;
  logic [7:0]   req_tile;
  logic         req_ready, src_valid, src_ready;
  logic [255:0] src_data, gbf_wr_data;
  logic [4:0]   gbf_wr_addr;
  logic         actv_en1a, actv_we1a, actv_en2a, actv_we2a;
  logic         wgt_en1a, wgt_we1a, wgt_en2a, wgt_we2a;
  logic         gbf_actv_data_avail, gbf_wgt_data_avail;
  logic         gbf_actv_buf1_ready, gbf_actv_buf2_ready;
  logic         gbf_wgt_buf1_ready, gbf_wgt_buf2_ready;
  logic         layer_done;
`ifdef GBF_REFILL_PERF_EN
  logic [31:0]  perf_src_stall, perf_req_wait;
`endif

  gbf_refill_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .cfg_actv_fills(cfg_actv_fills), .cfg_wgt_fills(cfg_wgt_fills), .cfg_beats(cfg_beats),
    .actv_gbf1_need_data(actv_gbf1_need_data), .actv_gbf2_need_data(actv_gbf2_need_data),
    .wgt_gbf1_need_data(wgt_gbf1_need_data), .wgt_gbf2_need_data(wgt_gbf2_need_data),
    .req_valid(req_valid), .req_id(req_id), .req_tile(req_tile), .req_ready(req_ready),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .gbf_wr_addr(gbf_wr_addr), .gbf_wr_data(gbf_wr_data),
    .actv_en1a(actv_en1a), .actv_we1a(actv_we1a), .actv_en2a(actv_en2a), .actv_we2a(actv_we2a),
    .wgt_en1a(wgt_en1a), .wgt_we1a(wgt_we1a), .wgt_en2a(wgt_en2a), .wgt_we2a(wgt_we2a),
    .gbf_actv_data_avail(gbf_actv_data_avail), .gbf_wgt_data_avail(gbf_wgt_data_avail),
    .gbf_actv_buf1_ready(gbf_actv_buf1_ready), .gbf_actv_buf2_ready(gbf_actv_buf2_ready),
    .gbf_wgt_buf1_ready(gbf_wgt_buf1_ready), .gbf_wgt_buf2_ready(gbf_wgt_buf2_ready),
    .layer_done(layer_done)
`ifdef GBF_REFILL_PERF_EN
    , .perf_src_stall(perf_src_stall), .perf_req_wait(perf_req_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   id;
    logic [4:0]   addr;
    logic [255:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"},
          {req_valid, req_id, req_tile, src_ready, gbf_wr_addr,
           actv_en1a, actv_we1a, actv_en2a, actv_we2a,
           wgt_en1a, wgt_we1a, wgt_en2a, wgt_we2a,
           gbf_actv_data_avail, gbf_wgt_data_avail,
           gbf_actv_buf1_ready, gbf_actv_buf2_ready,
           gbf_wgt_buf1_ready, gbf_wgt_buf2_ready, layer_done}, '0);
    check({tag, "_wdata"}, gbf_wr_data, '0);
  endtask

  task automatic start_layer(input logic [7:0] a, input logic [7:0] w, input logic [5:0] b);
    cfg_actv_fills = a;
    cfg_wgt_fills  = w;
    cfg_beats      = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_layer();
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
  endtask

  // Waits for a request, checks it, then streams nb beats; expected writes
  // go to the scoreboard as each beat is offered while src_ready is high.
  task automatic fill(input logic [1:0] id, input logic [7:0] tile, input int nb,
                      input bit gap, input int rdy_delay);
    int  n, k, cyc;
    bit  v;
    wr_t e;
    n = 0;
    while (!req_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_valid_seen", req_valid, 1);
    check("req_id", req_id, id);
    check("req_tile", req_tile, tile);
    for (int d = 0; d < rdy_delay; d++) begin
      @(negedge clk);
      check("req_hold_valid", req_valid, 1);
      check("req_hold_id", req_id, id);
      check("req_hold_tile", req_tile, tile);
    end
    req_ready = 1'b1;
    @(negedge clk);
    k = 0;
    cyc = 0;
    while (k < nb && cyc < 200) begin
      v = src_ready && (!gap || (cyc % 2 == 0));
      src_valid = v;
      src_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
      if (v) begin
        e.id = id;
        e.addr = 5'(k);
        e.data = src_data;
        exp_q.push_back(e);
      end
      @(negedge clk);
      if (v) k++;
      cyc++;
    end
    src_valid = 1'b0;
    check("beats_accepted", k, nb);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    repeat (12) begin
      if (layer_done) n++;
      @(negedge clk);
    end
    check("layer_done_pulses", n, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0;
    cfg_actv_fills = '0; cfg_wgt_fills = '0; cfg_beats = '0;
    actv_gbf1_need_data = 1'b0; actv_gbf2_need_data = 1'b0;
    wgt_gbf1_need_data = 1'b0; wgt_gbf2_need_data = 1'b0;
    req_ready = 1'b1; src_valid = 1'b0; src_data = '0;

    // Write monitor: every strobe must match the scoreboard head
    fork
      forever begin
        logic [3:0] ens, wes;
        wr_t e;
        @(negedge clk);
        ens = {wgt_en2a, wgt_en1a, actv_en2a, actv_en1a};
        wes = {wgt_we2a, wgt_we1a, actv_we2a, actv_we1a};
        if (ens != 4'd0 || wes != 4'd0) begin
          check("we_equals_en", wes, ens);
          if (exp_q.size() == 0) begin
            check("unexpected_write", ens, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_target", ens, 4'd1 << e.id);
            check("wr_addr", gbf_wr_addr, e.addr);
            check("wr_data", gbf_wr_data, e.data);
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    // Two fills per type, 4 beats each: 0, 2, 1, 3
    start_layer(8'd2, 8'd2, 6'd4);
    fill(2'd0, 8'd0, 4, 1'b0, 0);
    check("actv_avail_before", gbf_actv_data_avail, 0);
    @(negedge clk);
    check("actv_buf1_ready", gbf_actv_buf1_ready, 1);
    check("actv_avail_rise", gbf_actv_data_avail, 1);
    fill(2'd2, 8'd0, 4, 1'b0, 0);
    @(negedge clk);
    check("wgt_avail_rise", gbf_wgt_data_avail, 1);
    fill(2'd1, 8'd1, 4, 1'b0, 0);
    fill(2'd3, 8'd1, 4, 1'b0, 0);
    wait_done();
    check("all_ready", {gbf_actv_buf1_ready, gbf_actv_buf2_ready,
                        gbf_wgt_buf1_ready, gbf_wgt_buf2_ready}, 4'hF);
    check("sb_empty_1", exp_q.size(), 0);

    // cfg_beats = 0 selects a full 32-row fill
    clear_layer();
    check("finish_clears_ready", gbf_actv_buf1_ready, 0);
    start_layer(8'd1, 8'd0, 6'd0);
    fill(2'd0, 8'd0, 32, 1'b0, 0);
    @(negedge clk);
    check("full_depth_ready", gbf_actv_buf1_ready, 1);
    wait_done();

    // Source gaps and a delayed req_ready
    clear_layer();
    req_ready = 1'b0;
    start_layer(8'd1, 8'd0, 6'd4);
    fill(2'd0, 8'd0, 4, 1'b1, 3);
`ifdef GBF_REFILL_PERF_EN
    check("perf_src_stall", perf_src_stall, 3);
    check("perf_req_wait", perf_req_wait, 3);
`endif
    wait_done();

    // need_data rising edge recycles a FULL buffer
    clear_layer();
    start_layer(8'd3, 8'd0, 6'd2);
    fill(2'd0, 8'd0, 2, 1'b0, 0);
    fill(2'd1, 8'd1, 2, 1'b0, 0);
    @(negedge clk);
    check("both_actv_ready", {gbf_actv_buf1_ready, gbf_actv_buf2_ready}, 2'b11);
    check("no_req_while_full", req_valid, 0);
    actv_gbf1_need_data = 1'b1;
    @(negedge clk);
    check("buf1_released", gbf_actv_buf1_ready, 0);
    check("buf2_kept", gbf_actv_buf2_ready, 1);
    fill(2'd0, 8'd2, 2, 1'b0, 0);
    actv_gbf1_need_data = 1'b0;
    wait_done();

    // finish after 2 of 4 beats of the third fill
    clear_layer();
    start_layer(8'd2, 8'd1, 6'd4);
    fill(2'd0, 8'd0, 4, 1'b0, 0);
    fill(2'd2, 8'd0, 4, 1'b0, 0);
    fill(2'd1, 8'd1, 2, 1'b0, 0);
    check("avail_before_finish", {gbf_actv_data_avail, gbf_wgt_data_avail}, 2'b11);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    check("finish_idle", {req_valid, src_ready, layer_done}, 3'b000);
    check("finish_ready", {gbf_actv_buf1_ready, gbf_actv_buf2_ready,
                           gbf_wgt_buf1_ready, gbf_wgt_buf2_ready}, 4'h0);
    check("finish_avail", {gbf_actv_data_avail, gbf_wgt_data_avail}, 2'b00);
    src_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_we_after_finish", {actv_we1a, actv_we2a, wgt_we1a, wgt_we2a}, 4'h0);
    end
    src_valid = 1'b0;

    // Synchronous reset in the middle of a transfer
    start_layer(8'd2, 8'd0, 6'd4);
    fill(2'd0, 8'd0, 2, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_xfer");
`ifdef GBF_REFILL_PERF_EN
    check("perf_reset", {perf_src_stall, perf_req_wait}, 0);
`endif
    reset = 1'b0;
    start_layer(8'd1, 8'd1, 6'd2);
    fill(2'd0, 8'd0, 2, 1'b0, 0);
    fill(2'd2, 8'd0, 2, 1'b0, 0);
    wait_done();

    repeat (3) @(negedge clk);
    check("sb_empty_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
